// File: rtl/rsa_key_builder_if.sv
// Handshake and result bus between the prime-generation stage, the key
// builder and the downstream modular-exponentiation stage.
//   start      : request (driven by master)
//   p, q       : WORD_WIDTH/2-bit primes (driven by master)
//   busy, done : status / one-cycle completion pulse (driven by slave)
//   err        : key not built, valid with done
//   err_code   : 0 ok, 1 bad primes, 2 e>=phi, 3 gcd(e,phi)!=1
//   n, e, d    : modulus, public exponent, private exponent
interface rsa_key_builder_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic                      start;
  logic [WORD_WIDTH/2-1:0]   p;
  logic [WORD_WIDTH/2-1:0]   q;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic [1:0]                err_code;
  logic [WORD_WIDTH-1:0]     n;
  logic [WORD_WIDTH-1:0]     e;
  logic [WORD_WIDTH-1:0]     d;

  modport master (
    output start, p, q,
    input  busy, done, err, err_code, n, e, d
  );

  modport slave (
    input  start, p, q,
    output busy, done, err, err_code, n, e, d
  );
endinterface

// File: rtl/rsa_key_builder.sv
// Builds an RSA key from a prime pair: n = P*Q, phi = (P-1)(Q-1),
// e = PUB_EXP, d = e^-1 mod phi. Multiplication is a serial shift-add
// (LSB-first over Q); the inverse uses extended Euclid on a serial
// restoring divider.
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of rsa_key_builder_if (start/p/q in, results out)
module rsa_key_builder #(
  parameter int unsigned      WORD_WIDTH = 32,
  parameter longint unsigned  PUB_EXP    = 65537
) (
  input  logic              clk,
  input  logic              rst,
  rsa_key_builder_if.slave  bus
);
  localparam int unsigned HW = WORD_WIDTH / 2;
  localparam int unsigned TW = WORD_WIDTH + 2;
  localparam int unsigned CW = $clog2(WORD_WIDTH);

  localparam logic [WORD_WIDTH-1:0] E_VAL    = WORD_WIDTH'(PUB_EXP);
  localparam logic [CW-1:0]         MUL_LAST = CW'(HW - 1);
  localparam logic [CW-1:0]         DIV_LAST = CW'(WORD_WIDTH - 1);
  localparam logic [HW-1:0]         H_ONE    = HW'(1);
  localparam logic [HW-1:0]         H_THREE  = HW'(3);
  localparam logic signed [TW-1:0]  T_ONE    = TW'(1);
  localparam logic [WORD_WIDTH-1:0] W_ONE    = WORD_WIDTH'(1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] MUL_N    = 3'd2;
  localparam logic [2:0] MUL_PHI  = 3'd3;
  localparam logic [2:0] EGCD_DIV = 3'd4;
  localparam logic [2:0] EGCD_UPD = 3'd5;
  localparam logic [2:0] FIX      = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic [HW-1:0]          p_r, q_r;
  logic [WORD_WIDTH-1:0]  acc, mcand;
  logic [HW-1:0]          mplier;
  logic [WORD_WIDTH-1:0]  n_r, phi, d_r;
  logic [WORD_WIDTH-1:0]  r0, r1, rem, dvd;
  logic signed [TW-1:0]   t0, t1, qt;
  logic [1:0]             ecode;

  logic                   busy_r, done_r, err_r;
  logic [1:0]             err_code_r;
  logic [WORD_WIDTH-1:0]  n_out, e_out, d_out;

  logic [WORD_WIDTH-1:0]  acc_next;
  logic [WORD_WIDTH:0]    trial;
  logic                   qbit;
  logic [WORD_WIDTH-1:0]  rem_next;
  logic signed [TW-1:0]   qt_next;
  logic [WORD_WIDTH-1:0]  d_fix;
  logic                   bad_primes;

  always_comb begin
    acc_next   = mplier[0] ? acc + mcand : acc;
    trial      = {rem, dvd[WORD_WIDTH-1]};
    qbit       = trial >= {1'b0, r1};
    // trial - r1 < r1 whenever qbit is set, so the low word is exact
    rem_next   = qbit ? trial[WORD_WIDTH-1:0] - r1 : trial[WORD_WIDTH-1:0];
    // Horner accumulation of quotient*t1 as quotient bits arrive MSB-first
    qt_next    = (qt <<< 1) + (qbit ? t1 : '0);
    d_fix      = t0[TW-1] ? t0[WORD_WIDTH-1:0] + phi : t0[WORD_WIDTH-1:0];
    bad_primes = (p_r < H_THREE) || (q_r < H_THREE) || !p_r[0] || !q_r[0]
                 || (p_r == q_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      p_r        <= '0;
      q_r        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      n_r        <= '0;
      phi        <= '0;
      d_r        <= '0;
      r0         <= '0;
      r1         <= '0;
      rem        <= '0;
      dvd        <= '0;
      t0         <= '0;
      t1         <= '0;
      qt         <= '0;
      ecode      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= '0;
      n_out      <= '0;
      e_out      <= '0;
      d_out      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            p_r    <= bus.p;
            q_r    <= bus.q;
            ecode  <= '0;
            busy_r <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (bad_primes) begin
            ecode <= 2'd1;
            state <= DONE;
          end else begin
            acc    <= '0;
            mcand  <= {{HW{1'b0}}, p_r};
            mplier <= q_r;
            cnt    <= '0;
            state  <= MUL_N;
          end
        end
        MUL_N: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            n_r    <= acc_next;
            acc    <= '0;
            mcand  <= {{HW{1'b0}}, p_r - H_ONE};
            mplier <= q_r - H_ONE;
            cnt    <= '0;
            state  <= MUL_PHI;
          end
        end
        MUL_PHI: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            phi <= acc_next;
            if (acc_next <= E_VAL) begin
              ecode <= 2'd2;
              state <= DONE;
            end else begin
              // Euclid set-up folded into the last multiply cycle
              r0    <= acc_next;
              r1    <= E_VAL;
              t0    <= '0;
              t1    <= T_ONE;
              rem   <= '0;
              dvd   <= acc_next;
              qt    <= '0;
              cnt   <= '0;
              state <= EGCD_DIV;
            end
          end
        end
        EGCD_DIV: begin
          rem <= rem_next;
          dvd <= dvd << 1;
          qt  <= qt_next;
          cnt <= cnt + 1'b1;
          if (cnt == DIV_LAST) state <= EGCD_UPD;
        end
        EGCD_UPD: begin
          r0 <= r1;
          r1 <= rem;
          t0 <= t1;
          t1 <= t0 - qt;
          if (rem == '0) begin
            state <= FIX;
          end else begin
            rem   <= '0;
            dvd   <= r1;
            qt    <= '0;
            cnt   <= '0;
            state <= EGCD_DIV;
          end
        end
        FIX: begin
          if (r0 != W_ONE) ecode <= 2'd3;
          d_r   <= d_fix;
          state <= DONE;
        end
        DONE: begin
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          e_out      <= E_VAL;
          err_r      <= (ecode != 2'd0);
          err_code_r <= ecode;
          n_out      <= (ecode == 2'd0) ? n_r : '0;
          d_out      <= (ecode == 2'd0) ? d_r : '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.err_code = err_code_r;
  assign bus.n        = n_out;
  assign bus.e        = e_out;
  assign bus.d        = d_out;
endmodule
